io_led_switch: RTL

Peripheral-side responder for the memory-mapped IO path. It consumes the `LEDCtrl`/`SwitchCtrl` selects and `ioRead`/`ioWrite` strobes that the MemOrIO decoder produces, and owns the register state behind them:
- a 24-bit LED output register written by CPU `sw`;
- a synchronised, debounced 24-bit switch register returned to MemOrIO on `io_rdata` for CPU `lw`.

It sits between MemOrIO and the board pins.

---
 rtl/io_led_switch.sv | 113 +++++++++++
 1 files changed

// File: rtl/io_led_switch.sv
// io_led_switch: peripheral-side register block for the memory-mapped IO path.
// It owns the 24-bit LED output register written by CPU stores, and a
// synchronised, debounced copy of the 24 board switches returned to MemOrIO
// on io_rdata for CPU loads. Every output comes straight from a flop.

module io_led_switch #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic        LEDCtrl,
    input  logic        SwitchCtrl,
    input  logic [7:0]  ioAddr,
    input  logic [15:0] write_data,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out,
    output logic [15:0] io_rdata
);

    // Counter is just wide enough to reach DEBOUNCE_CYCLES-1, where it parks.
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Low byte of each register's address within the IO window.
    localparam logic [7:0] ADDR_LED_LO = 8'h60;
    localparam logic [7:0] ADDR_LED_HI = 8'h62;
    localparam logic [7:0] ADDR_SW_LO  = 8'h70;
    localparam logic [7:0] ADDR_SW_HI  = 8'h72;

    logic [23:0]      sync1;
    logic [23:0]      sync2;
    logic [23:0]      sample;
    logic [23:0]      stable;
    logic [CNT_W-1:0] cnt;

    logic [23:0]      led_next;
    logic [15:0]      rdata_next;

    // Two-flop synchroniser bringing the asynchronous switches into the clock domain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_in;
            sync2 <= sync1;
        end
    end

    // Debouncer: any bit change restarts the count for the whole vector; the
    // held value is accepted once it has survived DEBOUNCE_CYCLES further edges.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample <= '0;
            stable <= '0;
            cnt    <= '0;
        end else if (sync2 != sample) begin
            sample <= sync2;
            cnt    <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= sample;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next LED value: stores to the low half-word or the upper byte; others leave it alone.
    always_comb begin
        led_next = led_out;
        if (ioWrite && LEDCtrl) begin
            case (ioAddr)
                ADDR_LED_LO: led_next[15:0]  = write_data;
                ADDR_LED_HI: led_next[23:16] = write_data[7:0];
                default:     led_next        = led_out;
            endcase
        end
    end

    // LED register; a store with the switch region selected has no effect here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            led_out <= '0;
        end else begin
            led_out <= led_next;
        end
    end

    // Next read data: switch halves by address, zero for LED or unmapped reads, else hold.
    always_comb begin
        rdata_next = io_rdata;
        if (ioRead && SwitchCtrl) begin
            case (ioAddr)
                ADDR_SW_LO: rdata_next = stable[15:0];
                ADDR_SW_HI: rdata_next = {8'h00, stable[23:16]};
                default:    rdata_next = 16'h0000;
            endcase
        end else if (ioRead && LEDCtrl) begin
            rdata_next = 16'h0000;
        end
    end

    // Read data register, giving the one-cycle load latency MemOrIO expects.
    always_ff @(posedge clock) begin
        if (!reset) begin
            io_rdata <= '0;
        end else begin
            io_rdata <= rdata_next;
        end
    end

endmodule
